mem_bist_ctrl: RTL
==================

// Module: mem_bist_ctrl
// PURPOSE
//   Synthesisable built-in self-test controller for a single-port synchronous memory.
//   - Drives the memory's read/write/addr/data_in pins directly.
//   - Runs one or more write-then-read-back data patterns over every address.
//   - Compares data_out against expected data and reports pass/fail, error count and first failing address.
//   - Parametrised successor to the hand-coded memory test bench; usable in silicon and simulation.
// PARAMETERS
//   ADDR_W      5   address width; DEPTH = 2**ADDR_W locations tested
//   DATA_W      8   memory data width
//   RD_LATENCY  1   cycles from read=1 at a posedge to data_out valid at the next sampling posedge (>=1)
//   ERR_W       8   width of err_count (saturating)
// PORTS
//   clk              in   1        system clock, all logic on posedge
//   rst_n            in   1        reset, asynchronous, active-low
//   start            in   1        start request; sampled only in IDLE
//   mode             in   2        pattern select, latched at start: 0 zeros, 1 addr-as-data, 2 checkerboard, 3 all three in order
//   data_out         in   DATA_W   read data from memory
//   read             out  1        memory read strobe
//   write            out  1        memory write strobe
//   addr             out  ADDR_W   memory address
//   data_in          out  DATA_W   memory write data
//   busy             out  1        test in progress
//   done             out  1        test complete; held until next accepted start
//   pass             out  1        valid when done=1; 1 iff err_count==0
//   err_count        out  ERR_W    mismatches this run, saturates at all-ones
//   first_fail_addr  out  ADDR_W   address of first mismatch; 0 if none
// BEHAVIOUR
//   Reset (async, rst_n=0): every output 0, FSM->IDLE, compare pipeline cleared, immediately, incl. mid-run.
//   FSM: IDLE -> WR -> RD -> DRAIN -> (next pattern: WR | DONE); DONE -> WR on start; IDLE -> WR on start.
//   start accepted at edge E0 in IDLE/DONE:
//     - Latch mode; clear err_count, first_fail_addr, done, pass; set busy.
//     - start while busy is ignored.
//   WR: DEPTH cycles.
//     - write=1, read=0, addr = 0..DEPTH-1 ascending, one per cycle, data_in = pattern(addr).
//   RD: DEPTH cycles.
//     - read=1, write=0, addr ascending 0..DEPTH-1, back-to-back.
//     - data_in = 0 outside WR.
//   Compare pipeline:
//     - Expected data and addr delayed RD_LATENCY stages.
//     - data_out compared at the posedge RD_LATENCY cycles after each read edge.
//   DRAIN: RD_LATENCY cycles, read=0, finishing outstanding compares; then next pattern or DONE.
//   Patterns (all truncated/zero-extended to DATA_W):
//     - 0: all zeros.
//     - 1: addr zero-extended.
//     - 2: even addr -> ...0101 (0x55 for 8b); odd addr -> ...1010 (0xAA).
//   Mode 3: patterns 0,1,2 in sequence; errors accumulate across all three.
//   Mismatch: err_count += 1 unless all-ones. first_fail_addr loaded only on the first mismatch of the run.
//   Done: done=1, busy=0, pass=(err_count==0), read=write=addr=0.
//     - Edge at which done rises: E0 + NPAT*(2*DEPTH+RD_LATENCY) + 1 (NPAT=1, or 3 for mode 3).
//   Address counter wraps DEPTH-1 -> 0 only at phase change; never mid-phase.
// TESTING (ADDR_W=5, DATA_W=8, RD_LATENCY=1 unless stated; ideal memory model unless stated)
//   1. Assert rst_n=0 mid-WR -> all outputs 0 same time step; release, start -> clean full run, pass=1.
//   2. mode=0, good memory -> 32 write cycles, 32 read cycles.
//      done at E0+66, pass=1, err_count=0, first_fail_addr=0.
//   3. mode=1, addr 5 bit1 stuck-at-1 -> reads 0x07 vs 0x05.
//      err_count=1, first_fail_addr=5, pass=0.
//   4. mode=3, addr 0x1F always reads 0x00 -> zeros pass; addr(0x1F) and checkerboard(0xAA) fail.
//      err_count=2, first_fail_addr=0x1F, done at E0+196.
//   5. ERR_W=4, memory returns ~data for every addr, mode=0 -> 32 mismatches.
//      err_count=4'hF (saturated), first_fail_addr=0.
//   6. RD_LATENCY=2, good memory, mode=2; pulse start during RD -> start ignored.
//      pass=1, done at E0+67, write data alternates 0x55/0xAA.

Source files
------------

// File: rtl/mem_bist_ctrl.sv
// Built-in self-test controller for a single-port synchronous memory.
// Writes then reads back one or more data patterns and counts mismatches.
module mem_bist_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_fail_addr
);

    localparam int DW = $clog2(RD_LATENCY + 1);
    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam logic [DW-1:0] DLAST = DW'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_d;

    logic [ADDR_W-1:0] cnt;
    logic [DW-1:0]     dcnt;
    logic [1:0]        mode_q;
    logic [1:0]        pat;
    logic              accept;
    logic              mismatch;
    logic [DATA_W-1:0] expect_d;

    logic [RD_LATENCY-1:0] pv;
    logic [DATA_W-1:0]     pe [RD_LATENCY];
    logic [ADDR_W-1:0]     pa [RD_LATENCY];

    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        p,
        input logic [ADDR_W-1:0] a
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (p == 2'd1) begin
            v = DATA_W'(a);
        end else if (p == 2'd2) begin
            // Even addresses get ...0101, odd addresses ...1010.
            for (int i = 0; i < DATA_W; i++) begin
                v[i] = ((i % 2) == 0) ^ a[0];
            end
        end
        return v;
    endfunction

    assign accept   = (state == IDLE || state == DONE) && start && !busy;
    assign expect_d = pattern(pat, cnt);
    assign mismatch = pv[RD_LATENCY-1] &&
                      (data_out != pe[RD_LATENCY-1]);

    always_comb begin
        state_d = state;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        data_in = '0;
        unique case (state)
            IDLE, DONE: begin
                if (accept) state_d = WR;
            end
            WR: begin
                write   = 1'b1;
                addr    = cnt;
                data_in = expect_d;
                if (cnt == LAST) state_d = RD;
            end
            RD: begin
                read = 1'b1;
                addr = cnt;
                if (cnt == LAST) state_d = DRAIN;
            end
            DRAIN: begin
                if (dcnt == DLAST) begin
                    if (mode_q == 2'd3 && pat != 2'd2) state_d = WR;
                    else state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            dcnt            <= '0;
            mode_q          <= '0;
            pat             <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            pv              <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pe[i] <= '0;
                pa[i] <= '0;
            end
        end else begin
            // Expected data travels alongside the read to meet data_out.
            pv[0] <= read;
            pe[0] <= read ? expect_d : '0;
            pa[0] <= read ? cnt : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pa[i] <= pa[i-1];
            end

            if (state == WR || state == RD) cnt <= cnt + 1'b1;
            else cnt <= '0;

            if (state == DRAIN) dcnt <= dcnt + 1'b1;
            else dcnt <= '0;

            if (accept) begin
                mode_q          <= mode;
                pat             <= (mode == 2'd3) ? 2'd0 : mode;
                busy            <= 1'b1;
                done            <= 1'b0;
                pass            <= 1'b0;
                err_count       <= '0;
                first_fail_addr <= '0;
            end else begin
                if (state == DRAIN && state_d == WR) pat <= pat + 1'b1;
                if (mismatch) begin
                    if (err_count != '1) err_count <= err_count + 1'b1;
                    // Count never returns to zero, so zero marks the first miss.
                    if (err_count == '0) first_fail_addr <= pa[RD_LATENCY-1];
                end
                if (state == DONE && busy) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_count == '0);
                end
            end
        end
    end

endmodule
